// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci checker slice.
package fib_pkg;

  localparam int unsigned FIB_W = 32;
  localparam int unsigned SUM_W = 64;

  localparam logic [FIB_W-1:0] FIB_T0 = 32'd0;
  localparam logic [FIB_W-1:0] FIB_T1 = 32'd1;

  typedef enum logic [1:0] {
    StCollect,
    StReport,
    StDone
  } state_e;

endpackage

// File: rtl/fib_seq_checker_if.sv
// Term input stream plus result record handshake for fib_seq_checker.
interface fib_seq_checker_if
  import fib_pkg::*;
#(
  parameter int unsigned CntW = 8
);

  logic              in_valid;
  logic [FIB_W-1:0]  in_data;
  logic              out_ready;
  logic              out_valid;
  logic [SUM_W-1:0]  sum;
  logic [CntW-1:0]   count;
  logic              err;
  logic [CntW-1:0]   err_idx;
  logic              ovf;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  sum,
    input  count,
    input  err,
    input  err_idx,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output sum,
    output count,
    output err,
    output err_idx,
    output ovf
  );

endinterface

// File: rtl/fib_recur_check.sv
// Combinational check of one received term against the Fibonacci recurrence.
module fib_recur_check
  import fib_pkg::*;
#(
  parameter int unsigned CntW = 8
) (
  input  logic [CntW-1:0]  k_i,
  input  logic [FIB_W-1:0] prev1_i,
  input  logic [FIB_W-1:0] prev2_i,
  input  logic [FIB_W-1:0] in_data_i,
  output logic             mismatch_o,
  output logic             carry_o
);

  logic [FIB_W:0] recur_sum;
  logic [FIB_W:0] expected;

  assign recur_sum = {1'b0, prev1_i} + {1'b0, prev2_i};

  always_comb begin
    expected = recur_sum;
    if (k_i == CntW'(0)) begin
      expected = {1'b0, FIB_T0};
    end else if (k_i == CntW'(1)) begin
      expected = {1'b0, FIB_T1};
    end
  end

  assign mismatch_o = (expected[FIB_W-1:0] != in_data_i);
  // Only the recurrence terms can overflow; seeds are constants.
  assign carry_o    = expected[FIB_W];

endmodule

// File: rtl/fib_seq_checker.sv
// Collects N Fibonacci terms, checks the recurrence, then presents one result record.
module fib_seq_checker
  import fib_pkg::*;
#(
  parameter int unsigned N    = 10,
  parameter int unsigned CntW = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  fib_seq_checker_if.slave   bus
);

  state_e            state_q, state_d;
  logic [FIB_W-1:0]  prev1_q, prev1_d;
  logic [FIB_W-1:0]  prev2_q, prev2_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   err_idx_q, err_idx_d;
  logic              ovf_q, ovf_d;

  logic              mismatch;
  logic              carry;

  fib_recur_check #(
    .CntW (CntW)
  ) u_recur_check (
    .k_i        (count_q),
    .prev1_i    (prev1_q),
    .prev2_i    (prev2_q),
    .in_data_i  (bus.in_data),
    .mismatch_o (mismatch),
    .carry_o    (carry)
  );

  always_comb begin
    state_d   = state_q;
    prev1_d   = prev1_q;
    prev2_d   = prev2_q;
    sum_d     = sum_q;
    count_d   = count_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      StCollect: begin
        if (bus.in_valid) begin
          // History tracks received values so one bad term does not poison the rest.
          prev2_d = prev1_q;
          prev1_d = bus.in_data;
          sum_d   = sum_q + {{(SUM_W-FIB_W){1'b0}}, bus.in_data};
          count_d = count_q + CntW'(1);
          if (mismatch && !err_q) begin
            err_d     = 1'b1;
            err_idx_d = count_q;
          end
          if (carry) begin
            ovf_d = 1'b1;
          end
          if (count_q == CntW'(N - 1)) begin
            state_d = StReport;
          end
        end
      end
      StReport: begin
        if (bus.out_ready) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StCollect;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StCollect;
      prev1_q   <= '0;
      prev2_q   <= '0;
      sum_q     <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev1_q   <= prev1_d;
      prev2_q   <= prev2_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.out_valid = (state_q == StReport);
  assign bus.sum       = sum_q;
  assign bus.count     = count_q;
  assign bus.err       = err_q;
  assign bus.err_idx   = err_idx_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fib_seq_checker.sv
// Directed bench: two checkers (N=10, N=50) share one stimulus stream.
module tb_fib_seq_checker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  int n_tests;
  int n_fail;

  fib_seq_checker_if #(.CntW(8)) bus10 ();
  fib_seq_checker_if #(.CntW(8)) bus50 ();

  assign bus10.in_valid  = in_valid;
  assign bus10.in_data   = in_data;
  assign bus10.out_ready = out_ready;
  assign bus50.in_valid  = in_valid;
  assign bus50.in_data   = in_data;
  assign bus50.out_ready = out_ready;

  fib_seq_checker #(.N(10), .CntW(8)) dut10 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus10)
  );

  fib_seq_checker #(.N(50), .CntW(8)) dut50 (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus50)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] good [10];
  logic [31:0] bad  [10];
  logic [31:0] p1, p2, t;
  logic [63:0] sum50;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    good = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};
    bad  = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd4, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};
    out_ready = 1'b1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    tick();

    // Reset state
    check("rst_out_valid", bus10.out_valid, 0);
    check("rst_sum", bus10.sum, 0);
    check("rst_count", bus10.count, 0);
    check("rst_err", bus10.err, 0);
    check("rst_ovf", bus10.ovf, 0);
    rst = 1'b0;

    // Back-to-back correct run
    for (int i = 0; i < 9; i++) send(good[i]);
    check("b2b_no_valid_early", bus10.out_valid, 0);
    check("b2b_count9", bus10.count, 9);
    send(good[9]);
    check("b2b_out_valid", bus10.out_valid, 1);
    check("b2b_sum", bus10.sum, 88);
    check("b2b_count", bus10.count, 10);
    check("b2b_err", bus10.err, 0);
    check("b2b_ovf", bus10.ovf, 0);
    tick();
    check("b2b_done_valid", bus10.out_valid, 0);
    check("b2b_done_sum", bus10.sum, 88);

    // Mismatch at term 4; term 5 mismatches too but index sticks
    do_reset();
    for (int i = 0; i < 4; i++) send(bad[i]);
    check("err_before", bus10.err, 0);
    send(bad[4]);
    check("err_set", bus10.err, 1);
    check("err_idx_set", bus10.err_idx, 4);
    for (int i = 5; i < 10; i++) send(bad[i]);
    check("err_final", bus10.err, 1);
    check("err_idx_final", bus10.err_idx, 4);
    check("err_sum", bus10.sum, 89);
    check("err_valid", bus10.out_valid, 1);

    // N=50 wrapped sequence; first overflow at term 48
    do_reset();
    p1 = '0;
    p2 = '0;
    sum50 = '0;
    for (int k = 0; k < 50; k++) begin
      if (k == 0) t = 32'd0;
      else if (k == 1) t = 32'd1;
      else t = p1 + p2;
      p2 = p1;
      p1 = t;
      sum50 += {32'd0, t};
      if (k == 48) check("ovf_term48_val", t, 64'd512559680);
      send(t);
      if (k == 47) check("ovf_not_yet", bus50.ovf, 0);
      if (k == 48) check("ovf_at_48", bus50.ovf, 1);
    end
    check("ovf_flag", bus50.ovf, 1);
    check("ovf_err", bus50.err, 0);
    check("ovf_count", bus50.count, 50);
    check("ovf_sum", bus50.sum, sum50);
    check("ovf_valid", bus50.out_valid, 1);

    // Backpressure on the result record
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(good[i]);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 32'd100;
      tick();
      check("bp_hold_valid", bus10.out_valid, 1);
      check("bp_hold_sum", bus10.sum, 88);
      check("bp_hold_count", bus10.count, 10);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_xfer", bus10.out_valid, 0);
    for (int i = 0; i < 3; i++) send(32'd7);
    check("bp_done_valid", bus10.out_valid, 0);
    check("bp_done_sum", bus10.sum, 88);
    check("bp_done_count", bus10.count, 10);

    // Asynchronous reset mid-run
    do_reset();
    for (int i = 0; i < 4; i++) send(good[i]);
    check("ar_count4", bus10.count, 4);
    #2;
    rst = 1'b1;
    #1;
    check("ar_sum0", bus10.sum, 0);
    check("ar_count0", bus10.count, 0);
    check("ar_valid0", bus10.out_valid, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) send(good[i]);
    check("ar_sum", bus10.sum, 88);
    check("ar_count", bus10.count, 10);
    check("ar_err", bus10.err, 0);
    check("ar_valid", bus10.out_valid, 1);

    // Gapped input
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(good[i]);
      tick();
    end
    check("gap_sum", bus10.sum, 88);
    check("gap_count", bus10.count, 10);
    check("gap_err", bus10.err, 0);
    check("gap_ovf", bus10.ovf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
